fir_sequencer: RTL and testbench

FIR_SEQUENCER -- requirements
Module: fir_sequencer

---
 rtl/fir_sequencer_if.sv | 21 ++
 rtl/fir_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_fir_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_sequencer_if.sv
// Wishbone master bus between fir_sequencer and the FIR core's AXI-Lite/Wishbone bridge.
`timescale 1ns/1ps
interface fir_sequencer_if;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [31:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic        m_ack_i;
  logic [31:0] m_dat_i;

  modport master (
    output m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o,
    input  m_ack_i, m_dat_i
  );

  modport slave (
    input  m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o,
    output m_ack_i, m_dat_i
  );
endinterface

// File: rtl/fir_sequencer.sv
// Loads FIR taps over Wishbone, starts the core, streams len samples through it and polls ap_done.
// Define FIR_SEQ_TIMEOUT_EN to build the STREAM/POLL stall watchdog.
`timescale 1ns/1ps
module fir_sequencer #(
  parameter int NUM_TAPS    = 11,
  parameter int LEN_W       = 10,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [3:0]           tap_idx,
  input  logic [31:0]          tap_data,
  fir_sequencer_if.master      wb,
  input  logic                 in_tvalid,
  output logic                 in_tready,
  input  logic [31:0]          in_tdata,
  output logic                 ss_tvalid,
  input  logic                 ss_tready,
  output logic [31:0]          ss_tdata,
  output logic                 ss_tlast,
  input  logic                 sm_tvalid,
  output logic                 sm_tready,
  input  logic [31:0]          sm_tdata,
  input  logic                 sm_tlast,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic [31:0]          out_tdata
);

  localparam int                TAP_CW   = 5;
  localparam logic [TAP_CW-1:0] TAP_CNT  = TAP_CW'(NUM_TAPS);
  localparam logic [31:0]       ADR_CTRL = 32'h0000_0020;
  localparam logic [31:0]       ADR_TAP0 = 32'h0000_0040;

  typedef enum logic [2:0] {
    S_IDLE, S_TAP_WR, S_GAP, S_START_WR, S_STREAM, S_POLL, S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [TAP_CW-1:0] r_tap_k;
  logic [LEN_W-1:0]  r_len, r_in_cnt, r_out_cnt;
  logic              r_err, r_poll;

  logic              w_start_acc, w_in_open, w_in_hs, w_out_hs, w_out_last;
  logic              w_tlast_bad, w_wd_expire, w_stream;
  logic [LEN_W-1:0]  w_len_eff;
  logic [31:0]       w_tap_adr;
  logic              w_unused;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_len_eff   = (len == '0) ? LEN_W'(1) : len;
  assign w_tap_adr   = ADR_TAP0 + {25'd0, r_tap_k, 2'b00};
  assign w_stream    = (r_state == S_STREAM);

  // Both stream paths are wired through; the counters only observe handshakes.
  assign w_in_open  = w_stream && (r_in_cnt != r_len);
  assign ss_tvalid  = w_in_open && in_tvalid;
  assign in_tready  = w_in_open && ss_tready;
  assign ss_tdata   = w_in_open ? in_tdata : '0;
  assign ss_tlast   = w_in_open && (r_in_cnt == r_len - LEN_W'(1));
  assign w_in_hs    = ss_tvalid && ss_tready;

  assign out_tvalid  = w_stream && sm_tvalid;
  assign sm_tready   = w_stream && out_tready;
  assign out_tdata   = w_stream ? sm_tdata : '0;
  assign w_out_hs    = out_tvalid && out_tready;
  assign w_out_last  = (r_out_cnt == r_len - LEN_W'(1));
  assign w_tlast_bad = w_out_hs && (sm_tlast != w_out_last);

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign err     = r_err;
  assign tap_idx = r_tap_k[3:0];

`ifdef FIR_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wd;
  logic            w_wd_zone, w_wd_kick;

  assign w_wd_zone   = w_stream || (r_state == S_POLL);
  assign w_wd_kick   = w_in_hs || w_out_hs || wb.m_ack_i;
  // Fires on the TIMEOUT_CYC-th consecutive quiet cycle.
  assign w_wd_expire = w_wd_zone && !w_wd_kick && (r_wd == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_wd <= '0;
    else if (!w_wd_zone || w_wd_kick)
      r_wd <= '0;
    else
      r_wd <= r_wd + WD_W'(1);
  end

  assign w_unused = ^{wb.m_dat_i[31:2], wb.m_dat_i[0]};
`else
  assign w_wd_expire = 1'b0;
  assign w_unused    = ^{wb.m_dat_i[31:2], wb.m_dat_i[0], TIMEOUT_CYC};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    wb.m_cyc_o    = 1'b0;
    wb.m_stb_o    = 1'b0;
    wb.m_we_o     = 1'b0;
    wb.m_adr_o    = '0;
    wb.m_dat_o    = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_TAP_WR;
      end
      S_TAP_WR: begin
        wb.m_cyc_o = 1'b1;
        wb.m_stb_o = 1'b1;
        wb.m_we_o  = 1'b1;
        wb.m_adr_o = w_tap_adr;
        wb.m_dat_o = tap_data;
        if (wb.m_ack_i) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (r_poll)                w_state_nxt = S_POLL;
        else if (r_tap_k != TAP_CNT) w_state_nxt = S_TAP_WR;
        else                       w_state_nxt = S_START_WR;
      end
      S_START_WR: begin
        wb.m_cyc_o = 1'b1;
        wb.m_stb_o = 1'b1;
        wb.m_we_o  = 1'b1;
        wb.m_adr_o = ADR_CTRL;
        wb.m_dat_o = 32'h0000_0001;
        if (wb.m_ack_i) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (w_out_hs && w_out_last) w_state_nxt = S_POLL;
      end
      S_POLL: begin
        wb.m_cyc_o = 1'b1;
        wb.m_stb_o = 1'b1;
        wb.m_adr_o = ADR_CTRL;
        if (wb.m_ack_i) w_state_nxt = wb.m_dat_i[1] ? S_DONE : S_GAP;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_wd_expire) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tap_k   <= '0;
      r_len     <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_err     <= 1'b0;
      r_poll    <= 1'b0;
    end else if (w_start_acc) begin
      r_tap_k   <= '0;
      r_len     <= w_len_eff;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_err     <= 1'b0;
      r_poll    <= 1'b0;
    end else begin
      if ((r_state == S_TAP_WR) && wb.m_ack_i)
        r_tap_k <= r_tap_k + TAP_CW'(1);
      if ((r_state == S_POLL) && wb.m_ack_i && !wb.m_dat_i[1])
        r_poll <= 1'b1;
      if (w_in_hs)
        r_in_cnt <= r_in_cnt + LEN_W'(1);
      if (w_out_hs)
        r_out_cnt <= r_out_cnt + LEN_W'(1);
      if (w_tlast_bad || w_wd_expire)
        r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer: Wishbone slave, behavioural FIR core and stream endpoints.
`timescale 1ns/1ps
module tb_fir_sequencer;
  localparam int LEN_W = 10;
  localparam int NT    = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start;
  logic [LEN_W-1:0] len;
  logic             busy, done, err;
  logic [3:0]       tap_idx;
  logic [31:0]      tap_data;
  logic             in_tvalid, in_tready, ss_tvalid, ss_tready, ss_tlast;
  logic             sm_tvalid, sm_tready, sm_tlast, out_tvalid, out_tready;
  logic [31:0]      in_tdata, ss_tdata, sm_tdata, out_tdata;

  fir_sequencer_if wb();

  fir_sequencer #(.NUM_TAPS(NT), .LEN_W(LEN_W), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done), .err(err),
    .tap_idx(tap_idx), .tap_data(tap_data), .wb(wb),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata)
  );

  function automatic int tap_val(input int k);
    case (k)
      1: return -10;  2: return -9;  3: return 23;  4: return 56;  5: return 63;
      6: return 56;   7: return 23;  8: return -9;  9: return -10;
      default: return 0;
    endcase
  endfunction

  function automatic int xval(input int i);
    return ((i * 37) % 41) - 20;
  endfunction

  function automatic int golden(input int n);
    int y = 0;
    for (int k = 0; k < NT; k++)
      if (n - k >= 0) y += tap_val(k) * xval(n - k);
    return y;
  endfunction

  assign tap_data = tap_val(int'(tap_idx));

  // Bench knobs, written only by the main sequence.
  logic        tb_clr = 1'b1, stall_en = 1'b0, ss_block = 1'b0;
  int          tlast_pos = 49;
  logic [31:0] poll_resp [0:7];

  // Upstream source offers more samples than len so the gating is exercised.
  int in_idx, in_gap;
  assign in_tvalid = (in_idx < 64) && (in_gap == 0);
  assign in_tdata  = xval(in_idx);
  always @(posedge clk) begin
    if (tb_clr) begin
      in_idx <= 0; in_gap <= 0;
    end else if (in_tvalid && in_tready) begin
      in_idx <= in_idx + 1;
      in_gap <= stall_en ? int'($urandom_range(0, 3)) : 0;
    end else if (in_gap > 0) in_gap <= in_gap - 1;
  end

  // Behavioural FIR core: one result per sample, one cycle later, using the taps written over the bus.
  int cap_tap [0:15];
  int xs [0:127];
  int res [0:127];
  int ss_n, sm_idx, last_n, last_pos;

  function automatic int model_y(input int n, input int newx);
    int y, j;
    y = cap_tap[0] * newx;
    for (int k = 1; k < NT; k++) begin
      j = n - k;
      if (j >= 0) y += cap_tap[k[3:0]] * xs[j[6:0]];
    end
    return y;
  endfunction

  assign ss_tready = !ss_block;
  assign sm_tvalid = (sm_idx < ss_n);
  assign sm_tdata  = res[sm_idx[6:0]];
  assign sm_tlast  = (sm_idx == tlast_pos);
  always @(posedge clk) begin
    if (tb_clr) begin
      ss_n <= 0; sm_idx <= 0; last_n <= 0; last_pos <= -1;
    end else begin
      if (ss_tvalid && ss_tready) begin
        xs[ss_n[6:0]]  <= ss_tdata;
        res[ss_n[6:0]] <= model_y(ss_n, ss_tdata);
        ss_n <= ss_n + 1;
        if (ss_tlast) begin last_n <= last_n + 1; last_pos <= ss_n; end
      end
      if (sm_tvalid && sm_tready) sm_idx <= sm_idx + 1;
    end
  end

  // Wishbone slave: acks one cycle after the request and logs each completed access.
  logic        ack_r, prev_req, prev_acked, prev_we;
  logic [31:0] rdat_r, prev_adr, prev_dat;
  logic [31:0] acc_adr [0:31];
  logic [31:0] acc_dat [0:31];
  logic        acc_we  [0:31];
  int          acc_n, rd_n, gap_viol, hold_viol;
  assign wb.m_ack_i = ack_r;
  assign wb.m_dat_i = rdat_r;
  always @(posedge clk) begin
    if (tb_clr) begin
      ack_r <= 1'b0; rdat_r <= '0; prev_req <= 1'b0; prev_acked <= 1'b0;
      prev_we <= 1'b0; prev_adr <= '0; prev_dat <= '0;
      acc_n <= 0; rd_n <= 0; gap_viol <= 0; hold_viol <= 0;
    end else begin
      ack_r <= 1'b0;
      if (wb.m_cyc_o && wb.m_stb_o) begin
        if (ack_r) begin
          acc_adr[acc_n[4:0]] <= wb.m_adr_o;
          acc_dat[acc_n[4:0]] <= wb.m_dat_o;
          acc_we[acc_n[4:0]]  <= wb.m_we_o;
          acc_n <= acc_n + 1;
          if (!wb.m_we_o) rd_n <= rd_n + 1;
          if (wb.m_we_o && wb.m_adr_o[31:6] == 26'd1) cap_tap[wb.m_adr_o[5:2]] <= wb.m_dat_o;
        end else begin
          ack_r  <= 1'b1;
          rdat_r <= wb.m_we_o ? 32'd0 : poll_resp[rd_n[2:0]];
        end
        if (prev_acked) gap_viol <= gap_viol + 1;
        if (prev_req && !prev_acked &&
            (wb.m_adr_o != prev_adr || wb.m_dat_o != prev_dat || wb.m_we_o != prev_we))
          hold_viol <= hold_viol + 1;
      end
      prev_req   <= wb.m_cyc_o && wb.m_stb_o;
      prev_acked <= wb.m_cyc_o && wb.m_stb_o && ack_r;
      prev_adr   <= wb.m_adr_o;
      prev_dat   <= wb.m_dat_o;
      prev_we    <= wb.m_we_o;
    end
  end

  // Downstream sink and done counter.
  int got [0:127];
  int got_n, out_gap, done_cnt;
  assign out_tready = (out_gap == 0);
  always @(posedge clk) begin
    if (tb_clr) begin
      got_n <= 0; out_gap <= 0; done_cnt <= 0;
    end else begin
      if (out_tvalid && out_tready) begin
        got[got_n[6:0]] <= out_tdata;
        got_n   <= got_n + 1;
        out_gap <= stall_en ? int'($urandom_range(0, 3)) : 0;
      end else if (out_gap > 0) out_gap <= out_gap - 1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_tb();
    @(negedge clk) tb_clr = 1'b1;
    @(negedge clk) tb_clr = 1'b0;
  endtask

  task automatic run_seq(input int n, input int tl);
    tlast_pos = tl;
    len = LEN_W'(n);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 4000 && busy; c++) @(negedge clk);
    chk("run_end_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_stream(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) if (got[i[6:0]] != golden(i)) bad++;
    chk("out_count", got_n, n);
    chk("ss_count", ss_n, n);
    chk("tlast_count", last_n, 1);
    chk("tlast_pos", last_pos, n - 1);
    chk("out_data_bad", bad, 0);
    chk("done_pulses", done_cnt, 1);
    chk("wb_gap_viol", gap_viol, 0);
    chk("wb_hold_viol", hold_viol, 0);
  endtask

  task automatic check_taps();
    int bad = 0;
    for (int k = 0; k < NT; k++)
      if (acc_adr[k] != 32'h40 + 4 * k || acc_dat[k] != tap_val(k) || acc_we[k] !== 1'b1) bad++;
    chk("tap_writes_bad", bad, 0);
    chk("start_wr_adr", acc_adr[11], 32'h20);
    chk("start_wr_dat", acc_dat[11], 32'h1);
    chk("start_wr_we", {31'd0, acc_we[11]}, 32'd1);
    chk("poll_adr", acc_adr[12], 32'h20);
    chk("poll_we", {31'd0, acc_we[12]}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0;
    for (int i = 0; i < 8; i++) poll_resp[i] = 32'h2;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {29'd0, busy, done, err}, 32'd0);
    chk("rst_tap_idx", {28'd0, tap_idx}, 32'd0);
    chk("rst_wb", {29'd0, wb.m_cyc_o, wb.m_stb_o, wb.m_we_o}, 32'd0);
    chk("rst_wb_adr", wb.m_adr_o, 32'd0);
    chk("rst_streams", {28'd0, ss_tvalid, in_tready, sm_tready, out_tvalid}, 32'd0);
    rst = 1'b0;
    clr_tb();

    // Plain run, len=50, no stalls.
    run_seq(50, 49);
    chk("s1_acc_n", acc_n, 13);
    chk("s1_rd_n", rd_n, 1);
    check_taps();
    check_stream(50);
    chk("s1_in_consumed", in_idx, 50);
    chk("s1_err", {31'd0, err}, 32'd0);

    // Random 0-3 cycle stalls on both stream sides.
    clr_tb();
    stall_en = 1'b1;
    run_seq(50, 49);
    stall_en = 1'b0;
    check_stream(50);
    chk("s2_in_consumed", in_idx, 50);
    chk("s2_err", {31'd0, err}, 32'd0);

    // ap_done not ready for three polls.
    clr_tb();
    poll_resp[0] = 32'h0; poll_resp[1] = 32'h0; poll_resp[2] = 32'h0; poll_resp[3] = 32'h2;
    run_seq(50, 49);
    chk("s3_rd_n", rd_n, 4);
    chk("s3_acc_n", acc_n, 16);
    chk("s3_last_rd_adr", acc_adr[15], 32'h20);
    chk("s3_last_rd_we", {31'd0, acc_we[15]}, 32'd0);
    chk("s3_gap_viol", gap_viol, 0);
    chk("s3_done", done_cnt, 1);
    for (int i = 0; i < 8; i++) poll_resp[i] = 32'h2;

    // Early sm_tlast on result 10.
    clr_tb();
    run_seq(50, 10);
    chk("s4_err", {31'd0, err}, 32'd1);
    chk("s4_out_count", got_n, 50);
    chk("s4_done", done_cnt, 1);
    chk("s4_last_data", got[49], golden(49));

    // Reset in the middle of the tap writes, then a clean rerun.
    clr_tb();
    tlast_pos = 49; len = LEN_W'(50);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("s5_err_cleared", {31'd0, err}, 32'd0);
    for (int c = 0; c < 200 && !(tap_idx == 4'd5 && wb.m_cyc_o); c++) @(negedge clk);
    chk("s5_reach_k5", {28'd0, tap_idx}, 32'd5);
    rst = 1'b1;
    #1;
    chk("s5_rst_ctrl", {29'd0, busy, done, err}, 32'd0);
    chk("s5_rst_wb", {28'd0, wb.m_cyc_o, wb.m_stb_o, wb.m_we_o, tap_idx != 4'd0}, 32'd0);
    chk("s5_rst_adr", wb.m_adr_o, 32'd0);
    @(negedge clk) tb_clr = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(negedge clk) tb_clr = 1'b0;
    run_seq(50, 49);
    chk("s5_acc_n", acc_n, 13);
    chk("s5_first_adr", acc_adr[0], 32'h40);
    check_taps();
    check_stream(50);

    // len=0 behaves as a single sample.
    clr_tb();
    run_seq(0, 0);
    check_stream(1);
    chk("s6_in_consumed", in_idx, 1);

`ifdef FIR_SEQ_TIMEOUT_EN
    // Downstream FIR never accepts a sample; the watchdog aborts.
    clr_tb();
    ss_block = 1'b1;
    tlast_pos = 49; len = LEN_W'(50);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 60; c++) @(negedge clk);
    chk("wd_busy_early", {31'd0, busy}, 32'd1);
    for (int c = 0; c < 200 && busy; c++) @(negedge clk);
    chk("wd_busy", {31'd0, busy}, 32'd0);
    chk("wd_err", {31'd0, err}, 32'd1);
    chk("wd_no_done", done_cnt, 0);
    chk("wd_cyc", {31'd0, wb.m_cyc_o}, 32'd0);
    ss_block = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
